// File: rtl/cache_controller.sv
// 2-way set-associative write-back LRU cache controller.
// Owns tag/valid/dirty/LRU/data arrays and sequences hit/miss handling.
module cache_controller #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 3,
   parameter int SETS   = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_wren,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              hit,
   output logic              valid,
   output logic              lru,
   output logic              dirty,
   output logic              mem_req,
   output logic              mem_wren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - IDX_W;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CMP   = 3'd1;
   localparam logic [2:0] S_WB    = 3'd2;
   localparam logic [2:0] S_ALLOC = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state;
   logic              req_wren;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              first_r;
   logic              hit_r;
   logic              victim;
   logic              way_r;

   logic [TAG_W-1:0]  tag_a  [2][SETS];
   logic [DATA_W-1:0] data_a [2][SETS];
   logic [1:0][SETS-1:0] valid_a;
   logic [1:0][SETS-1:0] dirty_a;
   logic [SETS-1:0]   lru_a;

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  rtag;
   logic              hit0;
   logic              hit1;
   logic              hit_any;
   logic              hit_way;
   logic              vict;

   assign idx     = req_addr[IDX_W-1:0];
   assign rtag    = req_addr[ADDR_W-1:IDX_W];
   assign hit0    = valid_a[0][idx] && (tag_a[0][idx] == rtag);
   assign hit1    = valid_a[1][idx] && (tag_a[1][idx] == rtag);
   assign hit_any = hit0 | hit1;
   assign hit_way = ~hit0;

   // Fill an empty way first; only evict by LRU when the set is full.
   assign vict = !valid_a[0][idx] ? 1'b0 :
                 !valid_a[1][idx] ? 1'b1 : lru_a[idx];

   assign cpu_ready = (state == S_DONE);
   assign mem_req   = (state == S_WB) || (state == S_ALLOC);
   assign mem_wren  = (state == S_WB);
   assign mem_addr  = (state == S_WB)    ? {tag_a[victim][idx], idx} :
                      (state == S_ALLOC) ? req_addr : '0;
   assign mem_wdata = (state == S_WB) ? data_a[victim][idx] : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         req_wren  <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         first_r   <= 1'b0;
         hit_r     <= 1'b0;
         victim    <= 1'b0;
         way_r     <= 1'b0;
         valid_a   <= '0;
         dirty_a   <= '0;
         lru_a     <= '0;
         cpu_rdata <= '0;
         hit       <= 1'b0;
         valid     <= 1'b0;
         lru       <= 1'b0;
         dirty     <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (cpu_req) begin
                  req_wren  <= cpu_wren;
                  req_addr  <= cpu_addr;
                  req_wdata <= cpu_wdata;
                  first_r   <= 1'b1;
                  state     <= S_CMP;
               end
            end
            S_CMP: begin
               first_r <= 1'b0;
               if (first_r) hit_r <= hit_any;
               if (hit_any) begin
                  way_r <= hit_way;
                  if (req_wren) dirty_a[hit_way][idx] <= 1'b1;
                  else cpu_rdata <= data_a[hit_way][idx];
                  state <= S_DONE;
               end else begin
                  victim <= vict;
                  if (valid_a[vict][idx] && dirty_a[vict][idx])
                     state <= S_WB;
                  else
                     state <= S_ALLOC;
               end
            end
            S_WB: begin
               if (mem_ready) state <= S_ALLOC;
            end
            S_ALLOC: begin
               if (mem_ready) begin
                  valid_a[victim][idx] <= 1'b1;
                  dirty_a[victim][idx] <= 1'b0;
                  state <= S_CMP;
               end
            end
            S_DONE: begin
               lru_a[idx] <= ~way_r;
               hit        <= hit_r;
               valid      <= valid_a[way_r][idx];
               dirty      <= dirty_a[way_r][idx];
               lru        <= ~way_r;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Tag and data storage carry no reset; valid bits qualify them.
   always_ff @(posedge clock) begin
      if (state == S_CMP && hit_any && req_wren)
         data_a[hit_way][idx] <= req_wdata;
      if (state == S_ALLOC && mem_ready) begin
         data_a[victim][idx] <= mem_rdata;
         tag_a[victim][idx]  <= rtag;
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: hit/miss latency, write-back,
// stalled fills, reset during write-back and ignored mid-access requests.
module tb_cache_controller;

   logic       clock;
   logic       reset;
   logic       cpu_req;
   logic       cpu_wren;
   logic [4:0] cpu_addr;
   logic [2:0] cpu_wdata;
   logic       cpu_ready;
   logic [2:0] cpu_rdata;
   logic       hit;
   logic       valid;
   logic       lru;
   logic       dirty;
   logic       mem_req;
   logic       mem_wren;
   logic [4:0] mem_addr;
   logic [2:0] mem_wdata;
   logic       mem_ready;
   logic [2:0] mem_rdata;

   int total = 0;
   int bad   = 0;
   int lat;
   int n_wb;
   int n_fill;
   logic [4:0] wb_addr;
   logic [2:0] wb_data;
   logic [4:0] fill_addr;

   cache_controller dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_wren(cpu_wren),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .hit(hit), .valid(valid), .lru(lru), .dirty(dirty),
      .mem_req(mem_req), .mem_wren(mem_wren),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One CPU access; memory answers write-backs at once and fills after fw
   // cycles. rst_wb pulses reset on seeing a write-back; spur re-strobes
   // cpu_req with a foreign address during the access.
   task automatic access(input logic w, input logic [4:0] a,
                         input logic [2:0] d, input logic [2:0] fd,
                         input int fw, input logic rst_wb,
                         input logic spur);
      int cyc;
      int wc;
      bit done;
      lat = 0; n_wb = 0; n_fill = 0; wc = 0; done = 0;
      @(negedge clock);
      cpu_req = 1'b1; cpu_wren = w; cpu_addr = a; cpu_wdata = d;
      @(negedge clock);
      cpu_req = 1'b0;
      cyc = 1;
      while (!done && cyc < 60) begin
         mem_ready = 1'b0;
         if (spur) begin
            cpu_req  = (cyc == 1 || cyc == 2);
            cpu_addr = 5'h1F;
         end
         if (cpu_ready) begin
            lat = cyc;
            done = 1;
         end else if (mem_req && mem_wren) begin
            if (rst_wb) begin
               reset = 1'b1;
               #1;
               chk("rst_mem_req", 32'(mem_req), 0);
               chk("rst_cpu_ready", 32'(cpu_ready), 0);
               chk("rst_valid", 32'(valid), 0);
               done = 1;
            end else begin
               wb_addr = mem_addr;
               wb_data = mem_wdata;
               n_wb++;
               mem_ready = 1'b1;
            end
         end else if (mem_req) begin
            if (wc < fw) begin
               wc++;
               chk("stall_addr", 32'(mem_addr), 32'(a));
               chk("stall_wren", 32'(mem_wren), 0);
               chk("stall_rdy", 32'(cpu_ready), 0);
            end else begin
               fill_addr = mem_addr;
               mem_rdata = fd;
               n_fill++;
               mem_ready = 1'b1;
            end
         end
         @(negedge clock);
         cyc++;
      end
      mem_ready = 1'b0;
      cpu_req   = 1'b0;
      reset     = 1'b0;
   endtask

   initial begin
      int extra_rdy;
      int extra_req;
      reset = 1'b1; cpu_req = 0; cpu_wren = 0; cpu_addr = 0;
      cpu_wdata = 0; mem_ready = 0; mem_rdata = 0;
      repeat (3) @(negedge clock);
      chk("rst_ready", 32'(cpu_ready), 0);
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_status", 32'({hit, valid, lru, dirty}), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      reset = 1'b0;

      // T1 clean miss, fill way0
      access(0, 5'h05, 0, 3'd3, 0, 0, 0);
      chk("t1_lat", lat, 4);
      chk("t1_nfill", n_fill, 1);
      chk("t1_faddr", 32'(fill_addr), 5);
      chk("t1_nwb", n_wb, 0);
      chk("t1_rdata", 32'(cpu_rdata), 3);
      chk("t1_status", 32'({hit, valid, dirty, lru}), 32'b0101);

      // T2 read hit
      access(0, 5'h05, 0, 3'd0, 0, 0, 0);
      chk("t2_lat", lat, 2);
      chk("t2_nfill", n_fill, 0);
      chk("t2_rdata", 32'(cpu_rdata), 3);
      chk("t2_status", 32'({hit, valid, dirty, lru}), 32'b1101);

      // T3 write hit, fill way1, then dirty eviction of way0
      access(1, 5'h05, 3'd6, 3'd0, 0, 0, 0);
      chk("t3a_lat", lat, 2);
      chk("t3a_status", 32'({hit, valid, dirty, lru}), 32'b1111);
      access(0, 5'h0D, 0, 3'd2, 0, 0, 0);
      chk("t3b_lat", lat, 4);
      chk("t3b_faddr", 32'(fill_addr), 32'h0D);
      chk("t3b_rdata", 32'(cpu_rdata), 2);
      chk("t3b_status", 32'({hit, valid, dirty, lru}), 32'b0100);
      access(0, 5'h15, 0, 3'd4, 0, 0, 0);
      chk("t3c_lat", lat, 5);
      chk("t3c_nwb", n_wb, 1);
      chk("t3c_wbaddr", 32'(wb_addr), 32'h05);
      chk("t3c_wbdata", 32'(wb_data), 6);
      chk("t3c_faddr", 32'(fill_addr), 32'h15);
      chk("t3c_rdata", 32'(cpu_rdata), 4);
      chk("t3c_status", 32'({hit, valid, dirty, lru}), 32'b0101);

      // T4 fill stalled 5 cycles
      access(0, 5'h02, 0, 3'd5, 5, 0, 0);
      chk("t4_lat", lat, 9);
      chk("t4_faddr", 32'(fill_addr), 32'h02);
      chk("t4_rdata", 32'(cpu_rdata), 5);

      // T5 dirty both ways of set 1, reset during write-back
      access(1, 5'h0D, 3'd1, 3'd0, 0, 0, 0);
      chk("t5a_status", 32'({hit, valid, dirty, lru}), 32'b1110);
      access(1, 5'h15, 3'd7, 3'd0, 0, 0, 0);
      chk("t5b_status", 32'({hit, valid, dirty, lru}), 32'b1111);
      access(0, 5'h1D, 0, 3'd0, 0, 1, 0);
      access(0, 5'h05, 0, 3'd3, 0, 0, 0);
      chk("t5_lat", lat, 4);
      chk("t5_nwb", n_wb, 0);
      chk("t5_hit", 32'(hit), 0);

      // T6 stray cpu_req during a miss
      access(0, 5'h0D, 0, 3'd2, 0, 0, 1);
      chk("t6_lat", lat, 4);
      chk("t6_faddr", 32'(fill_addr), 32'h0D);
      chk("t6_nfill", n_fill, 1);
      extra_rdy = 0;
      extra_req = 0;
      repeat (8) begin
         @(negedge clock);
         if (cpu_ready) extra_rdy++;
         if (mem_req) extra_req++;
      end
      chk("t6_extra_rdy", extra_rdy, 0);
      chk("t6_extra_req", extra_req, 0);
      chk("t6_rdata", 32'(cpu_rdata), 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
